bug_result_logger: RTL and testbench
====================================

// Module: bug_result_logger
// PURPOSE
//  Downstream consumer of the bug-evaluation stage: samples its 5-bit result bus every qualified cycle.
//  Logs each change of result, with a cycle timestamp, into a small FIFO.
//  Host/testbench logic drains the FIFO through a valid/ready port; event and drop counters are exposed.
// PARAMETERS
//  RES_W   5   width of evaluated result word
//  TS_W    16  width of free-running timestamp counter (wraps)
//  DEPTH   8   FIFO entries; power of 2, >=2
//  CNT_W   16  width of event/drop counters (saturating)
// PORTS
//  clk          in   1              single clock, all logic on posedge
//  rst          in   1              asynchronous, active-low reset
//  clear        in   1              sync soft clear: flush FIFO, zero counters/timestamp, re-arm
//  in_valid     in   1              in_result is meaningful this cycle
//  in_result    in   RES_W          result word from bug_eval
//  out_valid    out  1              head entry present (FIFO not empty)
//  out_ready    in   1              consumer accepts head entry
//  out_result   out  RES_W          logged result of head entry
//  out_ts       out  TS_W           timestamp of head entry
//  level        out  $clog2(DEPTH)+1 current FIFO occupancy
//  evt_count    out  CNT_W          events accepted into FIFO
//  drop_count   out  CNT_W          events lost because FIFO full
//  overflow     out  1              sticky: set on first drop
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; FIFO empty; ts=0; FSM=ARM; last=0.
//  Timestamp: ts increments by 1 every cycle rst=1 and clear=0; wraps 2^TS_W-1 -> 0.
//  FSM ARM: first in_valid sample is always an event (even if 0) -> TRACK.
//  FSM TRACK: event when in_valid && in_result != last.
//  last updates on every in_valid sample.
//  Entry = {in_result, ts of the sampling cycle}.
//  Latency: event sampled in cycle N -> out_valid=1 in N+1 if FIFO was empty (registered FIFO, FWFT).
//  Handshake: pop when out_valid && out_ready.
//  out_* hold stable while out_valid && !out_ready.
//  out_ready with out_valid=0 is ignored.
//  Full, event, no pop: entry dropped; drop_count+1 (saturates at all-ones); overflow=1.
//  Full, event, pop same cycle: pop and push both occur; no drop; level unchanged.
//  Empty, event, out_ready=1: no bypass; entry appears next cycle.
//  Pointers wrap modulo DEPTH; level distinguishes full (DEPTH) from empty (0).
//  evt_count +1 per accepted push; saturates.
//  clear (sync, highest priority over push/pop):
//   - next cycle: FIFO empty, counters 0, overflow 0, ts 0, FSM=ARM;
//   - samples in the clear cycle are ignored.
//  Reset mid-operation: async, entries lost, identical to power-on reset.
// CONFIGURATION
//  BUG_LOG_NONZERO_FILTER_EN defined:
//   - a change to result 0 updates last but is not pushed;
//   - in ARM, a first sample of 0 moves FSM to TRACK without a push.
//  Undefined: every change, including to 0, is logged as above.
// STRUCTURE
//  Package bug_log_pkg:
//   - RES_W/TS_W defaults;
//   - typedef log_entry_t {result, ts};
//   - FSM state enum {ARM, TRACK}.
//  Sub-module bug_log_fifo:
//   - parameterised sync FIFO, FWFT, push/pop/full/empty/level, sync flush;
//   - storage for log_entry_t.
//  Top holds ts counter, change detector/FSM, counters, overflow flag.
// TESTING
//  1 Reset, then in_valid=1, result 00000 at ts=3 -> one entry {00000,3}; out_valid in next cycle.
//  2 Sequence 3,3,7,7,0 on consecutive cycles, out_ready=1 -> entries 3,7,0 with ts stepping 0,2,4 rel; evt_count=3.
//  3 out_ready=0, 10 distinct results, DEPTH=8 -> level=8, drop_count=2, overflow=1; drain -> first 8 in order.
//  4 FIFO full, event with out_ready=1 same cycle -> level stays 8, drop_count unchanged.
//  5 clear with 5 entries queued -> next cycle level=0, counters 0, ts 0; next sample logged as first.
//  6 With BUG_LOG_NONZERO_FILTER_EN: sequence 0,4,0,9 -> entries 4,9 only; without the macro -> 0,4,0,9.
//  Also: rst=0 pulse mid-drain -> all outputs 0 immediately (async), no stale entry after release.

Source files
------------

// File: rtl/bug_log_pkg.sv
// Shared types and sizes for the bug-result logger: log entry layout, FSM states,
// and a saturating-increment helper for the event/drop counters.
package bug_log_pkg;

   localparam int unsigned RES_W     = 5;
   localparam int unsigned TS_W      = 16;
   localparam int unsigned LOG_DEPTH = 8;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned LVL_W     = $clog2(LOG_DEPTH) + 1;

   typedef struct packed {
      logic [RES_W-1:0] result;
      logic [TS_W-1:0]  ts;
   } log_entry_t;

   typedef enum logic {
      ARM   = 1'b0,
      TRACK = 1'b1
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/bug_result_logger_if.sv
// Host-facing bus of the bug-result logger: sample input, drain port, status.
interface bug_result_logger_if;
   import bug_log_pkg::*;

   logic             clear;
   logic             in_valid;
   logic [RES_W-1:0] in_result;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_result;
   logic [TS_W-1:0]  out_ts;
   logic [LVL_W-1:0] level;
   logic [CNT_W-1:0] evt_count;
   logic [CNT_W-1:0] drop_count;
   logic             overflow;

   modport master (
      output clear, in_valid, in_result, out_ready,
      input  out_valid, out_result, out_ts, level, evt_count, drop_count, overflow
   );

   modport slave (
      input  clear, in_valid, in_result, out_ready,
      output out_valid, out_result, out_ts, level, evt_count, drop_count, overflow
   );

endinterface

// File: rtl/bug_log_fifo.sv
// First-word-fall-through sync FIFO of log entries with a registered head and
// synchronous flush. Pop is ignored while empty; push while full is accepted only with a pop.
module bug_log_fifo
   import bug_log_pkg::*;
#(
   parameter int unsigned DEPTH = LOG_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  log_entry_t             data_i,
   input  logic                   pop_i,
   output log_entry_t             head_o,
   output logic                   valid_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned FLVL_W = PTR_W + 1;

   log_entry_t              mem_q [DEPTH];
   logic       [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic       [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic       [FLVL_W-1:0] level_q, level_d;
   log_entry_t              head_q, head_d;
   logic                    valid_q, valid_d;
   logic                    do_pop_c, do_push_c, full_c, we_c;

   // Next-state: pointers and occupancy, plus the head register kept one step ahead of the array
   always_comb begin
      full_c    = (level_q == FLVL_W'(DEPTH));
      do_pop_c  = pop_i && valid_q;
      do_push_c = push_i && (!full_c || do_pop_c);
      we_c      = do_push_c && !flush_i;
      level_d   = level_q + FLVL_W'(do_push_c) - FLVL_W'(do_pop_c);
      rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop_c);
      wr_ptr_d  = wr_ptr_q + PTR_W'(do_push_c);
      head_d    = head_q;
      if (do_pop_c) begin
         if (level_q >= FLVL_W'(2)) head_d = mem_q[rd_ptr_d];
         else if (do_push_c)        head_d = data_i;
         else                       head_d = '0;
      end else if (!valid_q && do_push_c) begin
         head_d = data_i;
      end
      valid_d = (level_d != '0);
      if (flush_i) begin
         level_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         head_d   = '0;
         valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

   // Storage array needs no reset; occupancy tracking guards every read
   always_ff @(posedge clk) begin
      if (we_c) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = head_q;
   assign valid_o = valid_q;
   assign level_o = level_q;

endmodule

// File: rtl/bug_result_logger.sv
// Logs every change of the bug-evaluation result with a cycle timestamp into a FIFO.
// Build option BUG_LOG_NONZERO_FILTER_EN: changes to result 0 are tracked but not logged.
module bug_result_logger
   import bug_log_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   bug_result_logger_if.slave  bus
);

   state_e           state_q, state_d;
   logic [TS_W-1:0]  ts_q;
   logic [RES_W-1:0] last_q;
   logic [CNT_W-1:0] evt_q, drop_q;
   logic             ovf_q;

   logic             event_c, pop_c, full_c, drop_c, push_c;
   log_entry_t       entry_c, head;
   logic             fifo_valid;
   logic [LVL_W-1:0] fifo_level;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ARM;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.clear)                            state_d = ARM;
      else if (bus.in_valid && state_q == ARM)  state_d = TRACK;
   end

   // Event decode: first sample after arming always counts, later only on change
   always_comb begin
      event_c = 1'b0;
      if (bus.in_valid && !bus.clear) begin
         case (state_q)
            ARM:     event_c = 1'b1;
            TRACK:   event_c = (bus.in_result != last_q);
            default: event_c = 1'b0;
         endcase
`ifdef BUG_LOG_NONZERO_FILTER_EN
         if (bus.in_result == '0) event_c = 1'b0;
`endif
      end
   end

   always_comb begin
      pop_c          = fifo_valid && bus.out_ready;
      full_c         = (fifo_level == LVL_W'(LOG_DEPTH));
      drop_c         = event_c && full_c && !pop_c;
      push_c         = event_c && !drop_c;
      entry_c.result = bus.in_result;
      entry_c.ts     = ts_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts_q   <= '0;
         last_q <= '0;
         evt_q  <= '0;
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else if (bus.clear) begin
         ts_q   <= '0;
         last_q <= '0;
         evt_q  <= '0;
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (bus.in_valid) last_q <= bus.in_result;
         if (push_c)       evt_q  <= sat_inc(evt_q);
         if (drop_c) begin
            drop_q <= sat_inc(drop_q);
            ovf_q  <= 1'b1;
         end
      end
   end

   bug_log_fifo #(.DEPTH(LOG_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (bus.clear),
      .push_i  (push_c),
      .data_i  (entry_c),
      .pop_i   (bus.out_ready),
      .head_o  (head),
      .valid_o (fifo_valid),
      .level_o (fifo_level)
   );

   assign bus.out_valid  = fifo_valid;
   assign bus.out_result = head.result;
   assign bus.out_ts     = head.ts;
   assign bus.level      = fifo_level;
   assign bus.evt_count  = evt_q;
   assign bus.drop_count = drop_q;
   assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_bug_result_logger.sv
// Randomized and directed bench for bug_result_logger against a queue-based reference model.
module tb_bug_result_logger;
   import bug_log_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bug_result_logger_if bus ();

   bug_result_logger u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state
   log_entry_t      mq[$];
   logic [TS_W-1:0] m_ts;
   logic [RES_W-1:0] m_last;
   bit              m_arm;
   int              m_evt, m_drop;
   bit              m_ovf;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_ts   = '0;
      m_last = '0;
      m_arm  = 1'b1;
      m_evt  = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
   endfunction

   task automatic model_step();
      bit pop, ev;
      log_entry_t e;
      if (bus.clear) begin
         model_reset();
         return;
      end
      pop = (mq.size() != 0) && bus.out_ready;
      ev  = bus.in_valid && (m_arm || bus.in_result != m_last);
`ifdef BUG_LOG_NONZERO_FILTER_EN
      if (bus.in_result == '0) ev = 1'b0;
`endif
      if (pop) void'(mq.pop_front());
      if (ev) begin
         if (mq.size() == LOG_DEPTH) begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1'b1;
         end else begin
            e.result = bus.in_result;
            e.ts     = m_ts;
            mq.push_back(e);
            if (m_evt < 65535) m_evt++;
         end
      end
      if (bus.in_valid) begin
         m_last = bus.in_result;
         m_arm  = 1'b0;
      end
      m_ts = m_ts + TS_W'(1);
   endtask

   task automatic compare_all();
      chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("out_result", 64'(bus.out_result), 64'(mq[0].result));
         chk("out_ts", 64'(bus.out_ts), 64'(mq[0].ts));
      end
      chk("level", 64'(bus.level), 64'(mq.size()));
      chk("evt_count", 64'(bus.evt_count), 64'(m_evt));
      chk("drop_count", 64'(bus.drop_count), 64'(m_drop));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic sample(input int r);
      bus.in_valid  = 1'b1;
      bus.in_result = RES_W'(r);
      tick();
      bus.in_valid  = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
   endtask

   initial begin
      int seq2[5];
      int seq6[4];
      int ready_pct;
      seq2 = '{3, 3, 7, 7, 0};
      seq6 = '{0, 4, 0, 9};
      bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_result = '0; bus.out_ready = 1'b0;
      model_reset();
      #12;
      compare_all();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // First sample after reset, at ts=3, logged even when zero
      tick(); tick(); tick();
      bus.in_valid = 1'b1; bus.in_result = '0;
      tick();
      bus.in_valid = 1'b0;
`ifndef BUG_LOG_NONZERO_FILTER_EN
      chk("t1_valid", 64'(bus.out_valid), 64'd1);
      chk("t1_ts", 64'(bus.out_ts), 64'd3);
`else
      chk("t1_valid_filt", 64'(bus.out_valid), 64'd0);
`endif
      bus.out_ready = 1'b1; tick(); tick();

      // Change detection with consumer always ready
      do_clear();
      foreach (seq2[i]) sample(seq2[i]);
      tick(); tick();
`ifndef BUG_LOG_NONZERO_FILTER_EN
      chk("t2_evt", 64'(bus.evt_count), 64'd3);
`else
      chk("t2_evt_filt", 64'(bus.evt_count), 64'd2);
`endif

      // Overflow with stalled consumer, then full + simultaneous pop/push
      do_clear();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) sample(i + 1);
      chk("t3_level", 64'(bus.level), 64'd8);
      chk("t3_drop", 64'(bus.drop_count), 64'd2);
      chk("t3_ovf", 64'(bus.overflow), 64'd1);
      chk("t3_head", 64'(bus.out_result), 64'd1);
      bus.out_ready = 1'b1;
      sample(20);
      chk("t4_level", 64'(bus.level), 64'd8);
      chk("t4_drop", 64'(bus.drop_count), 64'd2);
      for (int i = 0; i < 10; i++) tick();
      chk("t4_empty", 64'(bus.level), 64'd0);

      // Clear with entries queued; next sample is a first event at ts 0
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) sample(i + 1);
      do_clear();
      chk("t5_level", 64'(bus.level), 64'd0);
      chk("t5_evt", 64'(bus.evt_count), 64'd0);
      sample(5);
      chk("t5_first", 64'(bus.out_valid), 64'd1);
      chk("t5_ts", 64'(bus.out_ts), 64'd0);

      // Zero-result filtering
      do_clear();
      foreach (seq6[i]) sample(seq6[i]);
`ifndef BUG_LOG_NONZERO_FILTER_EN
      chk("t6_level", 64'(bus.level), 64'd4);
`else
      chk("t6_level_filt", 64'(bus.level), 64'd2);
`endif

      // Asynchronous reset in the middle of a drain
      bus.out_ready = 1'b1;
      tick();
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_level", 64'(bus.level), 64'd0);
      chk("arst_evt", 64'(bus.evt_count), 64'd0);
      chk("arst_res", 64'(bus.out_result), 64'd0);
      chk("arst_ts", 64'(bus.out_ts), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      tick(); tick();

      // Random traffic with varying consumer throughput
      ready_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) ready_pct = int'($urandom_range(0, 100));
         bus.clear     = ($urandom_range(0, 149) == 0);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_result = ($urandom_range(0, 7) == 0) ? RES_W'($urandom_range(0, 31))
                                                     : RES_W'($urandom_range(0, 3));
         bus.out_ready = (int'($urandom_range(0, 99)) < ready_pct);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
